// File: rtl/uart_port_pkg.sv
// uart_port_pkg: shared definitions for the uart_port block.
//   uart_state_e      - state encoding shared by the TX and RX FSMs
//   DataWidth         - serial payload width (8 bits)
//   DefaultClksPerBit - clk_core cycles per bit at 39.75 MHz / 115200 baud
//   even_parity()     - parity helper used when UART_PARITY_EN is defined
package uart_port_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned DataWidth         = 8;
  localparam int unsigned DefaultClksPerBit = 345;

  function automatic logic even_parity(input logic [DataWidth-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_port_bit_timer.sv
// uart_port_bit_timer: loadable down-counter used for bit timing.
// Ports:
//   clk_core  in   clock, rising edge
//   reset     in   synchronous active-high reset (count -> 0)
//   load      in   load load_val this cycle (has priority over en)
//   load_val  in   value to load
//   en        in   count down by one while nonzero
//   zero      out  count is 0
// The counter stops at 0 instead of wrapping.
module uart_port_bit_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_core,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/uart_port.sv
// uart_port: byte-oriented 8N1 UART between core valid/ready ports and board pins.
// Optional build macro: UART_PARITY_EN adds an even parity bit (11-bit frame);
// without it the frame is pure 8N1. Port list is the same in both builds.
// Ports:
//   clk_core      in   core clock, rising edge
//   reset         in   synchronous active-high reset
//   tx_data       in   byte to transmit
//   tx_valid      in   tx_data valid
//   tx_ready      out  transmitter idle, accepts a byte
//   rx_data       out  last received byte
//   rx_valid      out  rx_data holds an unconsumed byte
//   rx_ready      in   consumer takes rx_data
//   rx_overrun    out  sticky: byte dropped while rx_valid was set
//   rx_frame_err  out  sticky: bad stop bit (or parity mismatch)
//   err_clear     in   pulse clears both sticky flags
//   txd           out  serial out, idle high
//   rxd           in   serial in, asynchronous
module uart_port
  import uart_port_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic                 clk_core,
  input  logic                 reset,
  input  logic [DataWidth-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DataWidth-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  input  logic                 err_clear,
  output logic                 txd,
  input  logic                 rxd
);

  localparam int unsigned TimerWidth = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitIdxW    = $clog2(DataWidth);
  localparam logic [TimerWidth-1:0] BitLoad  = TimerWidth'(CLKS_PER_BIT - 1);
  localparam logic [TimerWidth-1:0] HalfLoad = TimerWidth'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitIdxW-1:0]    LastBit  = BitIdxW'(DataWidth - 1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  uart_state_e          tx_state;
  logic [DataWidth-1:0] tx_shift;
  logic [BitIdxW-1:0]   tx_bit;
  logic [BitIdxW-1:0]   tx_bit_nxt;
  logic                 tx_accept;
  logic                 tx_load;
  logic                 tx_zero;

  assign tx_accept  = (tx_state == StIdle) && tx_valid && tx_ready;
  assign tx_bit_nxt = tx_bit + BitIdxW'(1);
  // Each timed state reloads on its final cycle, so every bit lasts CLKS_PER_BIT.
  assign tx_load    = (tx_state == StIdle) ? tx_accept : tx_zero;

  uart_port_bit_timer #(
    .Width (TimerWidth)
  ) u_tx_timer (
    .clk_core (clk_core),
    .reset    (reset),
    .load     (tx_load),
    .load_val (BitLoad),
    .en       (1'b1),
    .zero     (tx_zero)
  );

  always_ff @(posedge clk_core) begin
    if (reset) begin
      tx_state <= StIdle;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_ready <= 1'b1;
      txd      <= 1'b1;
    end else begin
      unique case (tx_state)
        StIdle: begin
          if (tx_accept) begin
            tx_shift <= tx_data;
            tx_ready <= 1'b0;
            txd      <= 1'b0;
            tx_state <= StStart;
          end
        end
        StStart: begin
          if (tx_zero) begin
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_state <= StData;
          end
        end
        StData: begin
          if (tx_zero) begin
            if (tx_bit == LastBit) begin
`ifdef UART_PARITY_EN
              txd      <= even_parity(tx_shift);
              tx_state <= StParity;
`else
              txd      <= 1'b1;
              tx_state <= StStop;
`endif
            end else begin
              tx_bit <= tx_bit_nxt;
              txd    <= tx_shift[tx_bit_nxt];
            end
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (tx_zero) begin
            txd      <= 1'b1;
            tx_state <= StStop;
          end
        end
`endif
        StStop: begin
          if (tx_zero) begin
            tx_ready <= 1'b1;
            tx_state <= StIdle;
          end
        end
        default: begin
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          tx_state <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rxd_meta;
  logic rxd_sync;
  logic rxd_prev;
  logic rx_fall;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Only a true high-to-low edge starts a frame, so after a bad stop bit the
  // receiver cannot restart until the line has gone high again.
  assign rx_fall = rxd_prev & ~rxd_sync;

  uart_state_e               rx_state;
  logic [DataWidth-1:0]      rx_shift;
  logic [BitIdxW-1:0]        rx_bit;
  logic                      rx_load;
  logic [TimerWidth-1:0]     rx_load_val;
  logic                      rx_zero;
  logic                      rx_bad;

  assign rx_load     = (rx_state == StIdle) ? rx_fall : rx_zero;
  // First wait is half a bit so later samples land mid-bit.
  assign rx_load_val = (rx_state == StIdle) ? HalfLoad : BitLoad;

  uart_port_bit_timer #(
    .Width (TimerWidth)
  ) u_rx_timer (
    .clk_core (clk_core),
    .reset    (reset),
    .load     (rx_load),
    .load_val (rx_load_val),
    .en       (1'b1),
    .zero     (rx_zero)
  );

`ifdef UART_PARITY_EN
  logic rx_parity_err;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      rx_parity_err <= 1'b0;
    end else if ((rx_state == StParity) && rx_zero) begin
      rx_parity_err <= (rxd_sync != even_parity(rx_shift));
    end
  end

  assign rx_bad = !rxd_sync || rx_parity_err;
`else
  assign rx_bad = !rxd_sync;
`endif

  always_ff @(posedge clk_core) begin
    if (reset) begin
      rx_state     <= StIdle;
      rx_shift     <= '0;
      rx_bit       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      // Consume and clear first; set events below override them in the same cycle.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (err_clear) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end

      unique case (rx_state)
        StIdle: begin
          if (rx_fall) begin
            rx_state <= StStart;
          end
        end
        StStart: begin
          if (rx_zero) begin
            if (rxd_sync) begin
              rx_state <= StIdle;
            end else begin
              rx_bit   <= '0;
              rx_state <= StData;
            end
          end
        end
        StData: begin
          if (rx_zero) begin
            rx_shift <= {rxd_sync, rx_shift[DataWidth-1:1]};
            rx_bit   <= rx_bit + BitIdxW'(1);
            if (rx_bit == LastBit) begin
`ifdef UART_PARITY_EN
              rx_state <= StParity;
`else
              rx_state <= StStop;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (rx_zero) begin
            rx_state <= StStop;
          end
        end
`endif
        StStop: begin
          if (rx_zero) begin
            rx_state <= StIdle;
            if (rx_bad) begin
              rx_frame_err <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end
        end
        default: begin
          rx_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: self-checking bench for uart_port with CLKS_PER_BIT = 16.
module tb_uart_port;

  localparam int unsigned Cpb = 16;
`ifdef UART_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif
  localparam int unsigned Budget = 4 * FrameBits * Cpb;

  logic       clk_core  = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready  = 1'b0;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       err_clear = 1'b0;
  logic       txd;
  logic       rxd;
  logic       loop_en   = 1'b0;
  logic       rxd_drv   = 1'b1;

  int checks   = 0;
  int failures = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk_core = ~clk_core;

  uart_port #(
    .CLKS_PER_BIT (Cpb)
  ) dut (
    .clk_core     (clk_core),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .err_clear    (err_clear),
    .txd          (txd),
    .rxd          (rxd)
  );

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic wait_tx_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < Budget; i++) begin
      if (tx_ready === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_rx_valid(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < Budget; i++) begin
      if (rx_valid === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic send_tx(input logic [7:0] d, output bit timed_out);
    wait_tx_idle(timed_out);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_level);
    for (int idx = 0; idx < int'(FrameBits); idx++) begin
      rxd_drv = (idx == int'(FrameBits) - 1) ? stop_level : frame_bit(d, idx);
      repeat (Cpb) tick();
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk_core);
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
    checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", rx_frame_err); end
    reset = 1'b0;
    tick();
  endtask

  // Checks txd cycle by cycle against the reference frame; poke_busy drives a
  // tx_valid pulse mid-frame which must be ignored.
  task automatic test_tx_frame(input logic [7:0] d, input bit poke_busy);
    bit   to;
    bit   bit_ok;
    bit   rdy_ok;
    logic bad_txd;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    send_tx(d, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL tx_accept_timeout data=%h tx_ready=%b exp=1", d, tx_ready);
      return;
    end
    for (int b = 0; b < int'(FrameBits); b++) begin
      bit_ok  = 1'b1;
      rdy_ok  = 1'b1;
      bad_txd = 1'b0;
      for (int c = 0; c < int'(Cpb); c++) begin
        @(negedge clk_core);
        if (txd !== frame_bit(d, b)) begin
          bit_ok  = 1'b0;
          bad_txd = txd;
        end
        if (tx_ready !== 1'b0) rdy_ok = 1'b0;
        if (poke_busy && b == 4 && c == 0) begin
          tx_data  = ~d;
          tx_valid = 1'b1;
        end
        if (poke_busy && b == 4 && c == 1) tx_valid = 1'b0;
      end
      checks++;
      if (!bit_ok) begin
        failures++;
        $display("FAIL tx_bit data=%h bit=%0d got=%b exp=%b", d, b, bad_txd, frame_bit(d, b));
      end
      checks++;
      if (!rdy_ok) begin
        failures++;
        $display("FAIL tx_ready_busy data=%h bit=%0d got=1 exp=0", d, b);
      end
    end
    @(negedge clk_core);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL tx_ready_after_frame data=%h got=%b exp=1", d, tx_ready);
    end
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("FAIL tx_idle_txd data=%h got=%b exp=1", d, txd);
    end
    if (poke_busy) begin
      repeat (3) @(negedge clk_core);
      checks++;
      if (tx_ready !== 1'b1 || txd !== 1'b1) begin
        failures++;
        $display("FAIL tx_busy_valid_ignored got_ready=%b got_txd=%b exp=1/1", tx_ready, txd);
      end
    end
  endtask

  task automatic test_tx_random();
    logic [7:0] d;
    for (int n = 0; n < 3; n++) begin
      d = 8'($urandom);
      test_tx_frame(d, (n == 1));
    end
  endtask

  task automatic test_loopback(input logic [7:0] d);
    bit to;
    loop_en  = 1'b1;
    rx_ready = 1'b0;
    send_tx(d, to);
    wait_rx_valid(to);
    @(negedge clk_core);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL loop_rx_timeout data=%h rx_valid=%b exp=1", d, rx_valid);
    end
    checks++;
    if (rx_data !== d) begin
      failures++;
      $display("FAIL loop_rx_data got=%h exp=%h", rx_data, d);
    end
    checks++;
    if (rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL loop_flags got_ovr=%b got_ferr=%b exp=0/0", rx_overrun, rx_frame_err);
    end
    tick();
    consume();
    @(negedge clk_core);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL loop_consume rx_valid got=%b exp=0", rx_valid);
    end
    wait_tx_idle(to);
    repeat (2) tick();
  endtask

  task automatic test_loopback_random();
    logic [7:0] sent_q[$];
    logic [7:0] d;
    logic [7:0] exp;
    bit         to;
    loop_en  = 1'b1;
    rx_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      sent_q.push_back(d);
      send_tx(d, to);
      wait_rx_valid(to);
      @(negedge clk_core);
      exp = sent_q.pop_front();
      checks++;
      if (to || rx_data !== exp) begin
        failures++;
        $display("FAIL rand_loop_data n=%0d got=%h exp=%h timeout=%0d", n, rx_data, exp, to);
      end
      tick();
      consume();
      wait_tx_idle(to);
    end
  endtask

  task automatic test_false_start();
    bit to;
    loop_en = 1'b0;
    rxd_drv = 1'b0;
    repeat (5) tick();
    rxd_drv = 1'b1;
    repeat (3 * Cpb) tick();
    @(negedge clk_core);
    checks++;
    if (rx_valid !== 1'b0 || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL false_start got_valid=%b ovr=%b ferr=%b exp=0/0/0",
               rx_valid, rx_overrun, rx_frame_err);
    end
    tick();
    drive_frame(8'h96, 1'b1);
    wait_rx_valid(to);
    @(negedge clk_core);
    checks++;
    if (to || rx_data !== 8'h96) begin
      failures++;
      $display("FAIL false_start_recover got=%h exp=96 timeout=%0d", rx_data, to);
    end
    tick();
    consume();
  endtask

  task automatic test_overrun();
    bit to;
    loop_en  = 1'b1;
    rx_ready = 1'b0;
    send_tx(8'h11, to);
    wait_tx_idle(to);
    send_tx(8'h22, to);
    wait_tx_idle(to);
    repeat (2) tick();
    @(negedge clk_core);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      failures++;
      $display("FAIL overrun_keep_old got_valid=%b got_data=%h exp=1/11", rx_valid, rx_data);
    end
    checks++;
    if (rx_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag got=%b exp=1", rx_overrun);
    end
    checks++;
    if (rx_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL overrun_no_ferr got=%b exp=0", rx_frame_err);
    end
    tick();
    pulse_err_clear();
    @(negedge clk_core);
    checks++;
    if (rx_overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=%b exp=0", rx_overrun);
    end
    tick();
    consume();
    @(negedge clk_core);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_consume rx_valid got=%b exp=0", rx_valid);
    end
    tick();
  endtask

  task automatic test_frame_err();
    bit to;
    loop_en = 1'b0;
    drive_frame(8'h55, 1'b0);
    repeat (2 * Cpb) tick();
    @(negedge clk_core);
    checks++;
    if (rx_frame_err !== 1'b1) begin
      failures++;
      $display("FAIL frame_err_flag got=%b exp=1", rx_frame_err);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_discard rx_valid got=%b exp=0", rx_valid);
    end
    tick();
    rxd_drv = 1'b1;
    repeat (2 * Cpb) tick();
    drive_frame(8'hC3, 1'b1);
    wait_rx_valid(to);
    @(negedge clk_core);
    checks++;
    if (to || rx_data !== 8'hC3) begin
      failures++;
      $display("FAIL frame_err_resume got=%h exp=c3 timeout=%0d", rx_data, to);
    end
    checks++;
    if (rx_frame_err !== 1'b1) begin
      failures++;
      $display("FAIL frame_err_sticky got=%b exp=1", rx_frame_err);
    end
    tick();
    pulse_err_clear();
    consume();
    @(negedge clk_core);
    checks++;
    if (rx_frame_err !== 1'b0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_clear got_ferr=%b got_valid=%b exp=0/0", rx_frame_err, rx_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_tx();
    bit to;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    send_tx(8'hA0, to);
    // Land in the middle of data bit 3 (frame bit 4), which is 0 for 0xA0.
    repeat (4 * Cpb + Cpb / 2) tick();
    @(negedge clk_core);
    checks++;
    if (txd !== 1'b0 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_tx_busy got_txd=%b got_ready=%b exp=0/0", txd, tx_ready);
    end
    @(posedge clk_core);
    #1;
    reset = 1'b1;
    @(posedge clk_core);
    @(negedge clk_core);
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_tx_reset got_txd=%b got_ready=%b exp=1/1", txd, tx_ready);
    end
    reset = 1'b0;
    tick();
    test_tx_frame(8'h0F, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_frame(8'hA5, 1'b0);
    test_tx_random();
    test_loopback(8'h3C);
    test_loopback_random();
    test_false_start();
    test_overrun();
    test_frame_err();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_port.md
Name: uart_port

Overview:
- Byte-oriented 8N1 UART between the CFM core I/O ports and the board TX/RX pins; replaces firmware bit-banging of outport[0]/inport[0].
- Runs on clk_core, the PLL output at 39.75 MHz.
- Core side uses valid/ready byte handshakes; pin side is raw txd/rxd.
- Instantiated in the board top alongside cfm_demo_top and driven by the same reset.

Parameters:
- CLKS_PER_BIT, 345, clk_core cycles per bit period (39.75 MHz / 115200); must be >= 4.

Ports:
- clk_core  in  1  core clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  transmitter idle, can accept a byte
- rx_data  out  8  last received byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer takes rx_data
- rx_overrun  out  1  sticky: byte dropped because rx_valid was still set
- rx_frame_err  out  1  sticky: stop bit sampled low
- err_clear  in  1  one-cycle pulse clears both sticky flags
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous

Behaviour:
- Reset values: txd=1, tx_ready=1, rx_valid=0, rx_data=0, rx_overrun=0, rx_frame_err=0, both FSMs in IDLE, rxd synchroniser flops=1. Reset mid-frame aborts immediately; txd returns high the cycle after reset is sampled.
- TX FSM states: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE. Each non-IDLE state lasts exactly CLKS_PER_BIT cycles.
- TX accept: on tx_valid & tx_ready, tx_data is latched and tx_ready drops the next cycle. txd goes low on that same next cycle.
- TX frame length: 10*CLKS_PER_BIT cycles. tx_ready reasserts the cycle after STOP completes, so back-to-back frames carry no extra idle bits. tx_valid while tx_ready=0 is ignored.
- RX input path: rxd passes through a 2-flop synchroniser; all decisions use the synchronised value.
- RX FSM IDLE: a high-to-low transition enters START.
- RX FSM START: after CLKS_PER_BIT/2 cycles, sample the line. If high, it is a false start: return to IDLE with no flags set. If low, enter DATA.
- RX FSM DATA: sample at 8 successive CLKS_PER_BIT intervals, shifting LSB first, then enter STOP.
- RX FSM STOP: sample once after CLKS_PER_BIT cycles.
  - Sample low: set rx_frame_err, discard the byte, wait for the line to go high, then IDLE.
  - Sample high: deliver the byte, then IDLE.
- RX delivery:
  - If rx_valid=0: rx_data <= byte and rx_valid <= 1 on the next cycle.
  - If rx_valid=1 and rx_ready=0 that cycle: new byte dropped, old rx_data kept, rx_overrun set.
  - If rx_valid=1 and rx_ready=1 in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
- rx_valid clears the cycle after rx_valid & rx_ready.
- Sticky flags: err_clear clears both. A set event in the same cycle as err_clear wins (flag ends 1).
- Bit counters: sized $clog2(CLKS_PER_BIT) bits, count down to 0, wrap-free. TX and RX are fully independent and may run concurrently.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: even parity bit inserted after DATA on TX, giving an 11-bit frame. RX samples the parity bit and recomputes it; on mismatch the byte is discarded and rx_frame_err is set.
- Undefined: pure 8N1 with no parity state. Port list is identical in both builds.

Decomposition:
- Shared include uart_defs.vh holds:
  - TX/RX state encodings: IDLE, START, DATA, PARITY, STOP.
  - Data width constant 8.
  - Default CLKS_PER_BIT.
- One natural sub-module: uart_bit_timer, a loadable down-counter with load value, enable and zero flag. It is instantiated once each for TX and RX.

Test Plan (CLKS_PER_BIT=16):
- Send 0xA5 on tx -> txd low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, high 16; tx_ready low for exactly 160 cycles.
- Loop txd to rxd, send 0x3C -> rx_valid rises with rx_data=0x3C; no flags set.
- Drive a 5-cycle low glitch on rxd -> false start; rx_valid=0 and no flags.
- Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, rx_overrun=1; err_clear -> flag 0.
- Frame 0x55 with stop bit forced low -> rx_frame_err=1, rx_valid=0; RX resumes after the line goes high.
- Assert reset mid-TX at bit 3 -> txd=1 and tx_ready=1 next cycle; a new 0x0F then transmits correctly.
